// File: rtl/regfile_lcd_scanner_if.sv
// -----------------------------------------------------------------------------
// regfile_lcd_scanner_if
//   Dual read port of the 8x8-bit register file, as seen by the LCD scanner.
//
//   ra1, ra2 : read addresses (driven by the scanner, master side)
//   rd1, rd2 : read data for ra1 / ra2 (driven by the register file, slave
//              side; combinational read path)
// -----------------------------------------------------------------------------
interface regfile_lcd_scanner_if;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] rd1;
    logic [7:0] rd2;

    modport master (output ra1, output ra2, input rd1, input rd2);
    modport slave  (input ra1, input ra2, output rd1, output rd2);
endinterface

// File: rtl/regfile_lcd_scanner.sv
// -----------------------------------------------------------------------------
// regfile_lcd_scanner
//   Read-side display sequencer for the 8x8-bit register file. Addresses
//   registers idx and idx+1 (mod 8), captures their read data and formats it
//   as two 6-character ASCII lines "Rn=HH " for the LCD character slots.
//   Auto-rotates every DWELL+1 cycles, or holds / single-steps on request.
//
//   Parameter
//     DWELL       SHOW-state cycles per register pair (2 .. 2^26-1)
//   Ports
//     clk         system clock, all state changes on rising edge
//     rst         synchronous active-high reset
//     hold        1 = freeze on current index
//     step        one-cycle pulse: advance index by one
//     rf          register file read port (master: ra1/ra2 out, rd1/rd2 in)
//     d0x0..d0x5  line-0 characters (register ra1)
//     d1x0..d1x5  line-1 characters (register ra2)
//     upd         one-cycle pulse: first character set for a new index valid
//     idx         index currently addressed
// -----------------------------------------------------------------------------
module regfile_lcd_scanner #(
    parameter int DWELL = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic                         step,
    regfile_lcd_scanner_if.master        rf,
    output logic [7:0]                   d0x0,
    output logic [7:0]                   d0x1,
    output logic [7:0]                   d0x2,
    output logic [7:0]                   d0x3,
    output logic [7:0]                   d0x4,
    output logic [7:0]                   d0x5,
    output logic [7:0]                   d1x0,
    output logic [7:0]                   d1x1,
    output logic [7:0]                   d1x2,
    output logic [7:0]                   d1x3,
    output logic [7:0]                   d1x4,
    output logic [7:0]                   d1x5,
    output logic                         upd,
    output logic [2:0]                   idx
);

    localparam logic [25:0] CNT_MAX = 26'(DWELL - 1);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic {
        LOAD = 1'b0,   // read addresses settling, no capture
        SHOW = 1'b1    // capture every cycle, count dwell
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] cnt_q;
    logic        advance;
    logic        capture;
    logic [2:0]  idx_next;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return CH_ZERO + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};   // 'A' - 10
    endfunction

    // step wins over auto-advance; both move the index by exactly one.
    assign advance  = step || (state_q == SHOW && cnt_q == CNT_MAX && !hold);
    assign capture  = (state_q == SHOW);
    assign idx_next = idx + 3'd1;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment first guarantees state_d is written on every
    // path, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = LOAD;
        end else if (state_q == LOAD) begin
            state_d = SHOW;
        end
    end

    // -------------------------------------------------------------------------
    // Index and read addresses (registered together so ra1/ra2 are valid for
    // the whole LOAD cycle)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= 3'd0;
            rf.ra1 <= 3'd0;
            rf.ra2 <= 3'd1;
        end else if (advance) begin
            idx    <= idx_next;
            rf.ra1 <= idx_next;
            rf.ra2 <= idx_next + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Dwell counter: cleared in LOAD and on any advance, saturates at DWELL-1
    // so that releasing hold advances on the very next edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (advance || state_q == LOAD) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 26'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Update pulse: the counter is zero only on the first SHOW cycle after a
    // LOAD (DWELL >= 2), which is exactly the first capture for a new index.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            upd <= 1'b0;
        end else begin
            upd <= capture && (cnt_q == '0);
        end
    end

    // -------------------------------------------------------------------------
    // Character registers: refreshed on every SHOW edge so register-file
    // writes show up one edge later without waiting for the next rotation.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            d0x0 <= CH_SPACE;
            d0x1 <= CH_SPACE;
            d0x2 <= CH_SPACE;
            d0x3 <= CH_SPACE;
            d0x4 <= CH_SPACE;
            d0x5 <= CH_SPACE;
            d1x0 <= CH_SPACE;
            d1x1 <= CH_SPACE;
            d1x2 <= CH_SPACE;
            d1x3 <= CH_SPACE;
            d1x4 <= CH_SPACE;
            d1x5 <= CH_SPACE;
        end else if (capture) begin
            d0x0 <= CH_R;
            d0x1 <= CH_ZERO + {5'b0, rf.ra1};
            d0x2 <= CH_EQ;
            d0x3 <= hex_char(rf.rd1[7:4]);
            d0x4 <= hex_char(rf.rd1[3:0]);
            d0x5 <= CH_SPACE;
            d1x0 <= CH_R;
            d1x1 <= CH_ZERO + {5'b0, rf.ra2};
            d1x2 <= CH_EQ;
            d1x3 <= hex_char(rf.rd2[7:4]);
            d1x4 <= hex_char(rf.rd2[3:0]);
            d1x5 <= CH_SPACE;
        end
    end

endmodule
